// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared states and constants for the vending controller
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [2:0] COIN1   = 3'd1;
  localparam logic [2:0] COIN2   = 3'd2;
  localparam logic [2:0] COIN5   = 3'd5;
  localparam logic [3:0] INV_MAX = 4'd15;

endpackage

// File: rtl/change_picker.sv
// rtl/change_picker.sv - greedy choice of the next change coin (5, then 2, then 1)
module change_picker
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] credit,
  input  logic [3:0]          inv1,
  input  logic [3:0]          inv2,
  input  logic [3:0]          inv5,
  output logic                p1,
  output logic                p2,
  output logic                p5
);

  localparam logic [CREDIT_W-1:0] C2 = CREDIT_W'(COIN2);
  localparam logic [CREDIT_W-1:0] C5 = CREDIT_W'(COIN5);

  always_comb begin
    p1 = 1'b0;
    p2 = 1'b0;
    p5 = 1'b0;
    if (credit >= C5 && inv5 != 4'd0) begin
      p5 = 1'b1;
    end else if (credit >= C2 && inv2 != 4'd0) begin
      p2 = 1'b1;
    end else if (credit != '0 && inv1 != 4'd0) begin
      p1 = 1'b1;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin/credit/inventory FSM serving water and snack with greedy change
module vend_controller
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 6,
  parameter int P_WATER    = 3,
  parameter int P_SNACK    = 4,
  parameter int MAX_CREDIT = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c1,
  input  logic                c2,
  input  logic                c5,
  input  logic                w,
  input  logic                s,
  input  logic                cr,
  input  logic                ld,
  input  logic [3:0]          ld1,
  input  logic [3:0]          ld2,
  input  logic [3:0]          ld5,
  output logic                wo,
  output logic                so,
  output logic                o1,
  output logic                o2,
  output logic                o5,
  output logic                rej,
  output logic                deny,
  output logic                short,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [3:0]          inv1,
  output logic [3:0]          inv2,
  output logic [3:0]          inv5
);

  localparam logic [CREDIT_W-1:0] PW   = CREDIT_W'(P_WATER);
  localparam logic [CREDIT_W-1:0] PS   = CREDIT_W'(P_SNACK);
  localparam logic [CREDIT_W:0]   CMAX = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit_n, price, pay;
  logic [CREDIT_W:0]   coin_sum;
  logic [3:0]          inv1_n, inv2_n, inv5_n;
  logic                wo_n, so_n, o1_n, o2_n, o5_n, rej_n, deny_n, short_n;
  logic                any_coin, one_coin, p1, p2, p5;
  logic [2:0]          coin_v;

  change_picker #(.CREDIT_W(CREDIT_W)) u_picker (
    .credit(credit), .inv1(inv1), .inv2(inv2), .inv5(inv5),
    .p1(p1), .p2(p2), .p5(p5)
  );

  assign any_coin = c1 | c2 | c5;
  assign one_coin = (c1 ^ c2 ^ c5) & ~(c1 & c2 & c5);
  assign coin_v   = c5 ? COIN5 : (c2 ? COIN2 : COIN1);
  assign coin_sum = {1'b0, credit} + (CREDIT_W+1)'(coin_v);
  assign price    = w ? PW : PS;
  assign pay      = p5 ? CREDIT_W'(COIN5) : (p2 ? CREDIT_W'(COIN2) : CREDIT_W'(COIN1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_n  = state;
    credit_n = credit;
    inv1_n   = inv1;
    inv2_n   = inv2;
    inv5_n   = inv5;
    wo_n     = 1'b0;
    so_n     = 1'b0;
    o1_n     = 1'b0;
    o2_n     = 1'b0;
    o5_n     = 1'b0;
    rej_n    = 1'b0;
    deny_n   = 1'b0;
    short_n  = 1'b0;
    if (state == IDLE) begin
      if (ld) begin
        inv1_n = ld1;
        inv2_n = ld2;
        inv5_n = ld5;
        rej_n  = any_coin;
        deny_n = w | s;
      end else if (cr) begin
        rej_n = any_coin;
        if (credit != '0) state_n = CHANGE;
      end else if ((w ^ s) && credit >= price) begin
        // price is taken at acceptance so credit already shows the remainder during VEND
        rej_n    = any_coin;
        credit_n = credit - price;
        wo_n     = w;
        so_n     = s;
        state_n  = VEND;
      end else begin
        deny_n = w | s;
        if (any_coin) begin
          if (one_coin && coin_sum <= CMAX &&
              ((c1 && inv1 < INV_MAX) || (c2 && inv2 < INV_MAX) || (c5 && inv5 < INV_MAX))) begin
            credit_n = coin_sum[CREDIT_W-1:0];
            if (c1) inv1_n = inv1 + 4'd1;
            if (c2) inv2_n = inv2 + 4'd1;
            if (c5) inv5_n = inv5 + 4'd1;
          end else begin
            rej_n = 1'b1;
          end
        end
      end
    end else begin
      // VEND and CHANGE both pay one coin per cycle so the first coin follows the dispense pulse
      rej_n = any_coin;
      if (credit == '0) begin
        state_n = IDLE;
      end else if (p1 || p2 || p5) begin
        o1_n     = p1;
        o2_n     = p2;
        o5_n     = p5;
        credit_n = credit - pay;
        if (p1) inv1_n = inv1 - 4'd1;
        if (p2) inv2_n = inv2 - 4'd1;
        if (p5) inv5_n = inv5 - 4'd1;
        state_n  = (credit == pay) ? IDLE : CHANGE;
      end else begin
        short_n = 1'b1;
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      credit <= '0;
      inv1   <= 4'd0;
      inv2   <= 4'd0;
      inv5   <= 4'd0;
      wo     <= 1'b0;
      so     <= 1'b0;
      o1     <= 1'b0;
      o2     <= 1'b0;
      o5     <= 1'b0;
      rej    <= 1'b0;
      deny   <= 1'b0;
      short  <= 1'b0;
    end else begin
      state  <= state_n;
      credit <= credit_n;
      inv1   <= inv1_n;
      inv2   <= inv2_n;
      inv5   <= inv5_n;
      wo     <= wo_n;
      so     <= so_n;
      o1     <= o1_n;
      o2     <= o2_n;
      o5     <= o5_n;
      rej    <= rej_n;
      deny   <= deny_n;
      short  <= short_n;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed self-checking bench for vend_controller
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       c1 = 0, c2 = 0, c5 = 0, w = 0, s = 0, cr = 0, ld = 0;
  logic [3:0] ld1 = 0, ld2 = 0, ld5 = 0;
  logic       wo, so, o1, o2, o5, rej, deny, short, busy;
  logic [5:0] credit;
  logic [3:0] inv1, inv2, inv5;
  int         checks = 0;
  int         errors = 0;

  vend_controller dut (
    .clk(clk), .rst(rst), .c1(c1), .c2(c2), .c5(c5), .w(w), .s(s), .cr(cr),
    .ld(ld), .ld1(ld1), .ld2(ld2), .ld5(ld5), .wo(wo), .so(so), .o1(o1),
    .o2(o2), .o5(o5), .rej(rej), .deny(deny), .short(short), .busy(busy),
    .credit(credit), .inv1(inv1), .inv2(inv2), .inv5(inv5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    c1 = 0; c2 = 0; c5 = 0; w = 0; s = 0; cr = 0; ld = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic coin(input int v);
    c1 = (v == 1); c2 = (v == 2); c5 = (v == 5);
    tick();
    clear_in();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (credit !== 6'd0) begin errors++; $display("FAIL rst_credit: got %0d exp 0", credit); end
    checks++; if ({inv1, inv2, inv5} !== 12'd0) begin errors++; $display("FAIL rst_inv: got %h exp 000", {inv1, inv2, inv5}); end
    checks++; if ({wo, so, o1, o2, o5, rej, deny, short, busy} !== 9'd0) begin
      errors++; $display("FAIL rst_outs: got %b exp 000000000", {wo, so, o1, o2, o5, rej, deny, short, busy}); end
  endtask

  task automatic test_water_change();
    ld = 1; ld1 = 3; ld2 = 1; ld5 = 1;
    tick(); clear_in();
    checks++; if ({inv1, inv2, inv5} !== 12'h311) begin errors++; $display("FAIL ld_inv: got %h exp 311", {inv1, inv2, inv5}); end
    coin(5);
    checks++; if (credit !== 6'd5 || inv5 !== 4'd2) begin errors++; $display("FAIL c5_credit: got %0d/%0d exp 5/2", credit, inv5); end
    coin(1);
    checks++; if (credit !== 6'd6 || inv1 !== 4'd4) begin errors++; $display("FAIL c1_credit: got %0d/%0d exp 6/4", credit, inv1); end
    w = 1; tick(); clear_in();
    checks++; if (wo !== 1'b1 || credit !== 6'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL vend_wo: got wo=%b credit=%0d busy=%b exp 1/3/1", wo, credit, busy); end
    tick();
    checks++; if (o2 !== 1'b1 || o1 !== 1'b0 || credit !== 6'd1 || inv2 !== 4'd0) begin
      errors++; $display("FAIL chg_o2: got o2=%b o1=%b credit=%0d inv2=%0d exp 1/0/1/0", o2, o1, credit, inv2); end
    tick();
    checks++; if (o1 !== 1'b1 || credit !== 6'd0 || busy !== 1'b0 || inv1 !== 4'd3) begin
      errors++; $display("FAIL chg_o1: got o1=%b credit=%0d busy=%b inv1=%0d exp 1/0/0/3", o1, credit, busy, inv1); end
    tick();
    checks++; if ({o1, o2, o5, wo} !== 4'd0) begin errors++; $display("FAIL chg_done: got %b exp 0000", {o1, o2, o5, wo}); end
  endtask

  task automatic test_deny();
    coin(2);
    s = 1; tick(); clear_in();
    checks++; if (deny !== 1'b1 || so !== 1'b0 || credit !== 6'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL snack_deny: got deny=%b so=%b credit=%0d busy=%b exp 1/0/2/0", deny, so, credit, busy); end
    w = 1; s = 1; tick(); clear_in();
    checks++; if (deny !== 1'b1 || wo !== 1'b0 || credit !== 6'd2) begin
      errors++; $display("FAIL both_deny: got deny=%b wo=%b credit=%0d exp 1/0/2", deny, wo, credit); end
  endtask

  task automatic test_reject();
    c1 = 1; c2 = 1; tick(); clear_in();
    checks++; if (rej !== 1'b1 || credit !== 6'd2 || inv1 !== 4'd3 || inv2 !== 4'd1) begin
      errors++; $display("FAIL multi_rej: got rej=%b credit=%0d inv1=%0d inv2=%0d exp 1/2/3/1", rej, credit, inv1, inv2); end
    for (int i = 0; i < 5; i++) coin(5);
    coin(1);
    checks++; if (credit !== 6'd28 || inv5 !== 4'd7) begin errors++; $display("FAIL fill_28: got %0d/%0d exp 28/7", credit, inv5); end
    coin(5);
    checks++; if (rej !== 1'b1 || credit !== 6'd28 || inv5 !== 4'd7) begin
      errors++; $display("FAIL ovf_rej: got rej=%b credit=%0d inv5=%0d exp 1/28/7", rej, credit, inv5); end
    coin(2);
    checks++; if (rej !== 1'b0 || credit !== 6'd30) begin errors++; $display("FAIL max_ok: got rej=%b credit=%0d exp 0/30", rej, credit); end
    coin(1);
    checks++; if (rej !== 1'b1 || credit !== 6'd30) begin errors++; $display("FAIL max_rej: got rej=%b credit=%0d exp 1/30", rej, credit); end
    cr = 1; tick(); clear_in();
    for (int i = 0; i < 20 && busy; i++) tick();
    checks++; if (busy !== 1'b0 || credit !== 6'd0 || inv5 !== 4'd1) begin
      errors++; $display("FAIL refund30: got busy=%b credit=%0d inv5=%0d exp 0/0/1", busy, credit, inv5); end
  endtask

  task automatic test_short();
    do_reset();
    coin(5);
    s = 1; tick(); clear_in();
    checks++; if (so !== 1'b1 || credit !== 6'd1) begin errors++; $display("FAIL short_so: got so=%b credit=%0d exp 1/1", so, credit); end
    tick();
    checks++; if (short !== 1'b1 || o1 !== 1'b0 || credit !== 6'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL short_pulse: got short=%b o1=%b credit=%0d busy=%b exp 1/0/1/0", short, o1, credit, busy); end
  endtask

  task automatic test_cancel_greedy();
    do_reset();
    ld = 1; ld1 = 0; ld2 = 0; ld5 = 0; c1 = 1; w = 1;
    tick(); clear_in();
    checks++; if (rej !== 1'b1 || deny !== 1'b1 || credit !== 6'd0 || inv1 !== 4'd0) begin
      errors++; $display("FAIL ld_prio: got rej=%b deny=%b credit=%0d inv1=%0d exp 1/1/0/0", rej, deny, credit, inv1); end
    coin(5); coin(1); coin(1);
    checks++; if (credit !== 6'd7) begin errors++; $display("FAIL cr_setup: got %0d exp 7", credit); end
    cr = 1; tick(); clear_in();
    checks++; if (busy !== 1'b1 || {o1, o2, o5} !== 3'd0 || credit !== 6'd7) begin
      errors++; $display("FAIL cr_enter: got busy=%b o=%b credit=%0d exp 1/000/7", busy, {o1, o2, o5}, credit); end
    c1 = 1; s = 1; tick(); clear_in();
    checks++; if (o5 !== 1'b1 || rej !== 1'b1 || deny !== 1'b0 || credit !== 6'd2 || inv5 !== 4'd0) begin
      errors++; $display("FAIL cr_o5: got o5=%b rej=%b deny=%b credit=%0d inv5=%0d exp 1/1/0/2/0", o5, rej, deny, credit, inv5); end
    tick();
    checks++; if (o1 !== 1'b1 || o2 !== 1'b0 || credit !== 6'd1 || inv1 !== 4'd1) begin
      errors++; $display("FAIL cr_o1a: got o1=%b o2=%b credit=%0d inv1=%0d exp 1/0/1/1", o1, o2, credit, inv1); end
    tick();
    checks++; if (o1 !== 1'b1 || credit !== 6'd0 || busy !== 1'b0 || short !== 1'b0) begin
      errors++; $display("FAIL cr_o1b: got o1=%b credit=%0d busy=%b short=%b exp 1/0/0/0", o1, credit, busy, short); end
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    coin(5); coin(5);
    cr = 1; tick(); clear_in();
    tick();
    checks++; if (o5 !== 1'b1 || credit !== 6'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got o5=%b credit=%0d busy=%b exp 1/5/1", o5, credit, busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || credit !== 6'd0 || inv5 !== 4'd0 || o5 !== 1'b0) begin
      errors++; $display("FAIL mid_async: got busy=%b credit=%0d inv5=%0d o5=%b exp 0/0/0/0", busy, credit, inv5, o5); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({wo, so, o1, o2, o5, rej, deny, short, busy} !== 9'd0 || credit !== 6'd0) begin
      errors++; $display("FAIL mid_after: got %b credit=%0d exp 000000000/0", {wo, so, o1, o2, o5, rej, deny, short, busy}, credit); end
  endtask

  initial begin
    test_reset();
    test_water_change();
    test_deny();
    test_reject();
    test_short();
    test_cancel_greedy();
    test_reset_mid_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
